uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_BIT, default 521, meaning clk cycles per serial bit (5 MHz clk_new / 9600 baud); legal range 2..4095.
REQ-002 The block SHALL have port clk  input  1  system clock, the divided MMCM output clk_new (5 MHz); all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 The block SHALL have port tx_en  input  1  transmitter enable; writes are ignored while 0.
REQ-005 The block SHALL have port tx_wr  input  1  single-cycle write strobe requesting transmission of tx_data.
REQ-006 The block SHALL have port tx_data  input  8  byte to transmit, sampled only in the accepting cycle.
REQ-007 The block SHALL have port tx_dout  output  1  serial line, idle high.
REQ-008 The block SHALL have port tx_busy  output  1  high while a frame is in progress.

Function
REQ-009 The block SHALL accept a write in a cycle where tx_wr=1, tx_en=1 and tx_busy=0; tx_data SHALL be latched on that edge.
REQ-010 The block SHALL drive tx_busy=1 and tx_dout=0 (start bit) from the edge following acceptance, with no further latency.
REQ-011 The block SHALL ignore tx_wr while tx_busy=1 or tx_en=0; neither the latched byte nor the timing SHALL change.
REQ-012 The frame SHALL be: start (0), data bits 0..7 LSB first, even parity bit (XOR of the 8 data bits), stop (1); 11 bits total.
REQ-013 Each bit SHALL be held on tx_dout for exactly CYCLES_PER_BIT cycles, timed by a bit-period counter cleared on acceptance and on every bit boundary.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START on acceptance, START->DATA, DATA->PARITY after the 8th bit (3-bit index wraps 7->0), PARITY->STOP, STOP->IDLE, each non-IDLE transition occurring when the bit counter reaches CYCLES_PER_BIT-1.
REQ-015 tx_busy SHALL be 1 in every non-IDLE state and SHALL fall on the edge that ends the stop bit, i.e. exactly 11*CYCLES_PER_BIT cycles after rising.
REQ-016 A write asserted in the first cycle tx_busy=0 SHALL be accepted, giving back-to-back frames with no idle gap beyond the one stop bit.
REQ-017 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks new writes.
REQ-018 tx_dout and tx_busy SHALL be registered outputs (glitch-free).
REQ-019 Bit-period counter width SHALL be ceil(log2(CYCLES_PER_BIT)) bits; it SHALL never exceed CYCLES_PER_BIT-1.

Reset
REQ-020 On reset=0 at a rising edge the block SHALL set tx_dout=1, tx_busy=0, FSM=IDLE, counters and latched byte to 0.
REQ-021 Reset asserted mid-frame SHALL abort immediately: tx_dout=1 and tx_busy=0 from the next edge; no partial bits are resumed.
REQ-022 A write in the same cycle as reset=0 SHALL be discarded.
REQ-023 After reset release the block SHALL accept a write in the first cycle reset=1.

Verification
REQ-024 CYCLES_PER_BIT=4, tx_en=1, write 0xA5 -> tx_dout 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; tx_busy high exactly 44 cycles.
REQ-025 Write 0x07 -> parity bit 1; write 0x00 -> parity bit 0, data bits all 0.
REQ-026 Write 0x55 then tx_wr pulses with 0xFF during the frame -> only 0x55 transmitted, tx_busy 44 cycles, then IDLE.
REQ-027 Write 0x3C, second write 0xC3 in the first cycle tx_busy=0 -> second start bit begins the next cycle; 88 busy cycles with one 1-cycle busy low gap.
REQ-028 tx_en=0 with tx_wr=1 -> tx_dout stays 1, tx_busy stays 0; tx_en dropped during a frame -> frame completes intact.
REQ-029 reset=0 during data bit 3 of 0xF0 -> next edge tx_dout=1, tx_busy=0; write 0x81 right after release -> clean full frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8E1 UART transmitter: start, 8 data bits LSB first, even parity, stop.
// Each bit is held for CYCLES_PER_BIT clocks; tx_dout and tx_busy are registered.
module uart_transmitter #(
    parameter int CYCLES_PER_BIT = 521
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_dout,
    output logic       tx_busy
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          dout_nxt, busy_nxt;
    logic          accept, bit_end;

    assign accept  = tx_wr & tx_en & ~tx_busy;
    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            data_q  <= '0;
            tx_dout <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            data_q  <= data_nxt;
            tx_dout <= dout_nxt;
            tx_busy <= busy_nxt;
        end
    end

    // Outputs are computed one cycle ahead so the registered line changes
    // exactly on the bit boundary.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        data_nxt  = data_q;
        dout_nxt  = tx_dout;
        busy_nxt  = tx_busy;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt = START;
                    data_nxt  = tx_data;
                    dout_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: if (bit_end) begin
                state_nxt = DATA;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                dout_nxt  = data_q[0];
            end
            DATA: if (bit_end) begin
                cnt_nxt = '0;
                idx_nxt = idx + 3'd1;
                if (idx == 3'd7) begin
                    state_nxt = PARITY;
                    dout_nxt  = ^data_q;
                end else begin
                    dout_nxt  = data_q[idx + 3'd1];
                end
            end
            PARITY: if (bit_end) begin
                state_nxt = STOP;
                cnt_nxt   = '0;
                dout_nxt  = 1'b1;
            end
            STOP: if (bit_end) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                dout_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                dout_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CYCLES_PER_BIT=4: frame bit patterns,
// busy length, ignored writes, back-to-back frames, tx_en gating and reset abort.
module tb_uart_transmitter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_dout;
    logic       tx_busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_transmitter #(.CYCLES_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_en   (tx_en),
        .tx_wr   (tx_wr),
        .tx_data (tx_data),
        .tx_dout (tx_dout),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller has just passed the accepting edge. mode 0: quiet,
    // 1: tx_wr held high with 0xFF throughout, 2: tx_en dropped mid-frame.
    // Ends in the first cycle after the frame (busy low), tx_wr left at 0.
    task automatic check_frame(input logic [7:0] b, input int mode);
        logic [10:0] exp;
        exp = {1'b1, ^b, b, 1'b0};
        for (int i = 0; i < 11 * CPB; i++) begin
            chk($sformatf("dout_%02h_bit%0d", b, i / CPB), tx_dout, exp[i / CPB]);
            chk($sformatf("busy_%02h_cyc%0d", b, i), tx_busy, 1);
            if (mode == 1) begin
                tx_wr   = 1'b1;
                tx_data = 8'hFF;
            end
            if (mode == 2 && i == 10) tx_en = 1'b0;
            step();
        end
        tx_wr = 1'b0;
        chk($sformatf("busy_fall_%02h", b), tx_busy, 0);
        chk($sformatf("idle_dout_%02h", b), tx_dout, 1);
    endtask

    task automatic write(input logic [7:0] b);
        tx_wr   = 1'b1;
        tx_data = b;
        step();
        tx_wr   = 1'b0;
        tx_data = ~b;
    endtask

    initial begin
        reset   = 1'b0;
        tx_en   = 1'b1;
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        repeat (3) step();
        chk("rst_dout", tx_dout, 1);
        chk("rst_busy", tx_busy, 0);
        reset = 1'b1;
        step();
        chk("post_rst_dout", tx_dout, 1);
        chk("post_rst_busy", tx_busy, 0);

        write(8'hA5); check_frame(8'hA5, 0);
        step();
        write(8'h07); check_frame(8'h07, 0);
        write(8'h00); check_frame(8'h00, 0);

        // Writes during a frame are ignored
        write(8'h55); check_frame(8'h55, 1);
        step();
        chk("after_noise_busy", tx_busy, 0);
        chk("after_noise_dout", tx_dout, 1);

        // Back-to-back: second write in the first busy-low cycle
        write(8'h3C); check_frame(8'h3C, 0);
        write(8'hC3); check_frame(8'hC3, 0);

        // tx_en gating
        tx_en   = 1'b0;
        tx_wr   = 1'b1;
        tx_data = 8'h99;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("en0_dout_%0d", i), tx_dout, 1);
            chk($sformatf("en0_busy_%0d", i), tx_busy, 0);
        end
        tx_wr = 1'b0;
        tx_en = 1'b1;
        step();
        write(8'h6B); check_frame(8'h6B, 2);
        tx_en = 1'b1;

        // Reset during data bit 3 of 0xF0 (frame bit 4, cycles 16..19)
        write(8'hF0);
        repeat (17) step();
        chk("f0_bit3_dout", tx_dout, 0);
        chk("f0_bit3_busy", tx_busy, 1);
        reset   = 1'b0;
        tx_wr   = 1'b1;
        tx_data = 8'h81;
        step();
        chk("abort_dout", tx_dout, 1);
        chk("abort_busy", tx_busy, 0);
        reset = 1'b1;
        step();
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        check_frame(8'h81, 0);
        step();
        chk("final_busy", tx_busy, 0);
        chk("final_dout", tx_dout, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
